// File: rtl/bfly_seq_if.sv
// Control bus between the butterfly sequencer and the surrounding
// operand, ALU and result logic.
interface bfly_seq_if #(
    parameter int CNT_W = 8
);
    // Handshakes: a transfer happens on a rising clock edge where valid and
    // ready are both high; valid, once raised, holds until that edge.
    logic             start;
    logic [CNT_W-1:0] num_bfly;
    logic             in_valid;
    logic             in_ready;
    logic             ld_op;
    logic             mul_en;
    logic [1:0]       mul_sel;
    logic [1:0]       mux3_sel;
    logic             s11;
    logic             s22;
    logic             s33;
    logic             s44;
    logic             s55;
    logic             s66;
    logic             s77;
    logic             s88;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] bfly_idx;
    logic [3:0]       state_dbg;

    modport master (
        input  start, num_bfly, in_valid, out_ready,
        output in_ready, ld_op, mul_en, mul_sel, mux3_sel,
        output s11, s22, s33, s44, s55, s66, s77, s88,
        output out_valid, busy, done, bfly_idx, state_dbg
    );

    modport slave (
        output start, num_bfly, in_valid, out_ready,
        input  in_ready, ld_op, mul_en, mul_sel, mux3_sel,
        input  s11, s22, s33, s44, s55, s66, s77, s88,
        input  out_valid, busy, done, bfly_idx, state_dbg
    );
endinterface

// File: rtl/bfly_seq.sv
// Sequencer for the shared 8-bit multiply/accumulate butterfly datapath:
// one operand set in, eight ALU steps, one result set out, repeated num_bfly times.
module bfly_seq #(
    parameter int CNT_W = 8
) (
    input  logic       clock,
    input  logic       n_rst,
    bfly_seq_if.master bus
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        LOAD = 4'd1,
        PRE  = 4'd2,
        S1   = 4'd3,
        S2   = 4'd4,
        S3   = 4'd5,
        S4   = 4'd6,
        S5   = 4'd7,
        S6   = 4'd8,
        S7   = 4'd9,
        S8   = 4'd10,
        OUT  = 4'd11,
        FIN  = 4'd12
    } state_t;

    typedef struct packed {
        logic       in_ready;
        logic       mul_en;
        logic [1:0] mul_sel;
        logic [1:0] mux3_sel;
        logic [7:0] strobe;
        logic       out_valid;
        logic       busy;
        logic       done;
    } ctrl_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] idx_q;
    logic             last_bfly;

    assign last_bfly = (idx_q == (num_q - ONE));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.start) state_nxt = (bus.num_bfly == '0) ? FIN : LOAD;
            LOAD: if (bus.in_valid) state_nxt = PRE;
            PRE:  state_nxt = S1;
            S1:   state_nxt = S2;
            S2:   state_nxt = S3;
            S3:   state_nxt = S4;
            S4:   state_nxt = S5;
            S5:   state_nxt = S6;
            S6:   state_nxt = S7;
            S7:   state_nxt = S8;
            S8:   state_nxt = OUT;
            OUT:  if (bus.out_ready) state_nxt = last_bfly ? FIN : LOAD;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Each step preloads the product the following step consumes, so the
    // multiplier always runs one step ahead of the ALU.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c      = '0;
        c.busy = (s != IDLE);
        unique case (s)
            LOAD: c.in_ready = 1'b1;
            PRE:  c.mul_en   = 1'b1;
            S1: begin
                c.strobe = 8'h01; c.mul_en = 1'b1; c.mul_sel = 2'd1; c.mux3_sel = 2'd0;
            end
            S2: begin
                c.strobe = 8'h02; c.mul_en = 1'b1; c.mul_sel = 2'd2; c.mux3_sel = 2'd2;
            end
            S3: begin
                c.strobe = 8'h04; c.mul_en = 1'b1; c.mul_sel = 2'd3; c.mux3_sel = 2'd1;
            end
            S4: begin
                c.strobe = 8'h08; c.mul_en = 1'b1; c.mul_sel = 2'd0; c.mux3_sel = 2'd2;
            end
            S5: begin
                c.strobe = 8'h10; c.mul_en = 1'b1; c.mul_sel = 2'd1; c.mux3_sel = 2'd0;
            end
            S6: begin
                c.strobe = 8'h20; c.mul_en = 1'b1; c.mul_sel = 2'd2; c.mux3_sel = 2'd2;
            end
            S7: begin
                c.strobe = 8'h40; c.mul_en = 1'b1; c.mul_sel = 2'd3; c.mux3_sel = 2'd1;
            end
            S8: begin
                c.strobe = 8'h80; c.mux3_sel = 2'd2;
            end
            OUT: c.out_valid = 1'b1;
            FIN: c.done      = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they belong to.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            state  <= IDLE;
            ctrl_q <= '0;
            num_q  <= '0;
            idx_q  <= '0;
        end else begin
            state  <= state_nxt;
            ctrl_q <= decode(state_nxt);
            if (state == IDLE && bus.start) begin
                num_q <= bus.num_bfly;
                idx_q <= '0;
            end else if (state == OUT && bus.out_ready && !last_bfly) begin
                idx_q <= idx_q + ONE;
            end
        end
    end

    assign bus.in_ready  = ctrl_q.in_ready;
    assign bus.ld_op     = bus.in_valid & ctrl_q.in_ready;
    assign bus.mul_en    = ctrl_q.mul_en;
    assign bus.mul_sel   = ctrl_q.mul_sel;
    assign bus.mux3_sel  = ctrl_q.mux3_sel;
    assign {bus.s88, bus.s77, bus.s66, bus.s55,
            bus.s44, bus.s33, bus.s22, bus.s11} = ctrl_q.strobe;
    assign bus.out_valid = ctrl_q.out_valid;
    assign bus.busy      = ctrl_q.busy;
    assign bus.done      = ctrl_q.done;
    assign bus.bfly_idx  = idx_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_bfly_seq.sv
// Bench for bfly_seq: a small butterfly datapath driven by the sequencer's
// controls, directed operand tables with hand-computed results.
module tb_bfly_seq;

    localparam int CNT_W = 8;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic n_rst = 1'b0;
    int   cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    bfly_seq_if #(.CNT_W(CNT_W)) bus ();

    bfly_seq #(.CNT_W(CNT_W)) dut (
        .clock (clock),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // ---------------- datapath driven by the sequencer ----------------
    logic [7:0] op_ar, op_ai, op_br, op_bi, op_wr, op_wi;
    logic [7:0] ar, ai, br, bi, wr, wi;
    logic [7:0] reg_mul, reg_alu, rey, imy, rez, imz;
    logic [7:0] addend, alu_res;
    logic [7:0] strobes;
    logic       neg;

    assign strobes = {bus.s88, bus.s77, bus.s66, bus.s55, bus.s44, bus.s33, bus.s22, bus.s11};

    function automatic logic [7:0] mul8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = a * b;
        return p[7:0];
    endfunction

    always_comb begin
        addend  = (bus.mux3_sel == 2'd0) ? ar : (bus.mux3_sel == 2'd1) ? ai : reg_alu;
        neg     = bus.s22 | bus.s55 | bus.s77 | bus.s88;
        alu_res = neg ? addend - reg_mul : addend + reg_mul;
    end

    always @(posedge clock) begin
        if (bus.ld_op) begin
            ar <= op_ar; ai <= op_ai; br <= op_br; bi <= op_bi; wr <= op_wr; wi <= op_wi;
        end
        if (bus.mul_en) begin
            case (bus.mul_sel)
                2'd0: reg_mul <= mul8(wr, br);
                2'd1: reg_mul <= mul8(wi, bi);
                2'd2: reg_mul <= mul8(wr, bi);
                default: reg_mul <= mul8(wi, br);
            endcase
        end
        if (bus.s11 | bus.s33 | bus.s55 | bus.s77) reg_alu <= alu_res;
        if (bus.s22) rey <= alu_res;
        if (bus.s44) imy <= alu_res;
        if (bus.s66) rez <= alu_res;
        if (bus.s88) imz <= alu_res;
    end

    // ---------------- event counters ----------------
    int done_cnt = 0;
    int ld_cnt   = 0;

    always @(negedge clock) begin
        if (bus.done)  done_cnt++;
        if (bus.ld_op) ld_cnt++;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0]  ar, ai, br, bi, wr, wi;
        logic [31:0] exp;   // {rey, imy, rez, imz}
    } vec_t;

    vec_t        vt[6];
    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;

    int msel_e[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int mx3_e[8]  = '{0, 2, 1, 2, 0, 2, 1, 2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] outs_packed();
        return {6'd0, bus.in_ready, bus.ld_op, bus.mul_en, bus.mul_sel, bus.mux3_sel,
                strobes, bus.out_valid, bus.busy, bus.done, bus.bfly_idx};
    endfunction

    // ---------------- driver ----------------
    // One run of n butterflies from vt[base..]; optional input stall before
    // butterfly in_stall, output stall on butterfly out_stall, and a stray
    // start pulse mid-run when poke is set.
    task automatic do_run(input int n, input int base, input int in_stall,
                          input int out_stall, input bit poke);
        int          start_cyc, ld0, dn0, wt, k, exp_len;
        logic [31:0] held;
        logic [7:0]  one_hot;
        ld0 = ld_cnt;
        dn0 = done_cnt;
        @(negedge clock);
        chk("idle_before_start", {31'd0, bus.busy}, 32'd0);
        bus.start    = 1'b1;
        bus.num_bfly = n[7:0];
        start_cyc    = cyc;
        @(negedge clock);
        bus.start    = 1'b0;
        bus.num_bfly = 8'hAA;
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(vt[base + i].exp);
            if (i == in_stall) begin
                repeat (4) begin
                    chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd1);
                    chk("stall_no_ld_op", {31'd0, bus.ld_op}, 32'd0);
                    @(negedge clock);
                end
            end
            op_ar = vt[base + i].ar; op_ai = vt[base + i].ai;
            op_br = vt[base + i].br; op_bi = vt[base + i].bi;
            op_wr = vt[base + i].wr; op_wi = vt[base + i].wi;
            bus.in_valid = 1'b1;
            #1;
            chk("ld_op_handshake", {31'd0, bus.ld_op}, 32'd1);
            chk("bfly_idx", {24'd0, bus.bfly_idx}, i);
            for (int o = 1; o <= 9; o++) begin
                @(negedge clock);
                if (o == 1) bus.in_valid = 1'b0;
                if (poke && i == 0 && o == 3) begin
                    bus.start = 1'b1; bus.num_bfly = 8'd5;
                end
                if (poke && i == 0 && o == 4) bus.start = 1'b0;
                chk("busy_in_bfly", {31'd0, bus.busy}, 32'd1);
                chk("in_ready_low", {31'd0, bus.in_ready}, 32'd0);
                if (o == 1) begin
                    chk("pre_strobes", {24'd0, strobes}, 32'd0);
                    chk("pre_mul_en", {31'd0, bus.mul_en}, 32'd1);
                    chk("pre_mul_sel", {30'd0, bus.mul_sel}, 32'd0);
                end else begin
                    k       = o - 1;
                    one_hot = 8'b1 << (k - 1);
                    chk($sformatf("s%0d_strobe", k), {24'd0, strobes}, {24'd0, one_hot});
                    chk($sformatf("s%0d_mul_en", k), {31'd0, bus.mul_en}, (k <= 7) ? 32'd1 : 32'd0);
                    chk($sformatf("s%0d_mul_sel", k), {30'd0, bus.mul_sel}, msel_e[k - 1]);
                    chk($sformatf("s%0d_mux3_sel", k), {30'd0, bus.mux3_sel}, mx3_e[k - 1]);
                end
            end
            @(negedge clock);
            chk("out_valid_latency", {31'd0, bus.out_valid}, 32'd1);
            if (i == out_stall) begin
                bus.out_ready = 1'b0;
                held = {rey, imy, rez, imz};
                repeat (5) begin
                    @(negedge clock);
                    chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
                    chk("stall_results", {rey, imy, rez, imz}, held);
                end
                bus.out_ready = 1'b1;
            end
            chk($sformatf("result_%0d", i), {rey, imy, rez, imz}, exp_q.pop_front());
            chk("out_bfly_idx", {24'd0, bus.bfly_idx}, i);
            @(negedge clock);
        end
        wt = 0;
        while (!bus.done && wt < 40) begin
            @(negedge clock);
            wt++;
        end
        chk("done_seen", {31'd0, bus.done}, 32'd1);
        exp_len = 1 + 11 * n + ((in_stall >= 0 && in_stall < n) ? 4 : 0)
                + ((out_stall >= 0 && out_stall < n) ? 5 : 0);
        chk("done_cycle", cyc - start_cyc, exp_len);
        @(negedge clock);
        chk("done_single_cycle", {31'd0, bus.done}, 32'd0);
        chk("idle_after_done", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(negedge clock);
        chk("done_pulse_count", done_cnt - dn0, 32'd1);
        chk("ld_op_count", ld_cnt - ld0, n);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int dn0, wt;
        // ar, ai, br, bi, wr, wi -> {rey, imy, rez, imz}
        vt[0] = '{8'd10,  8'd5,   8'd3,   8'd2,   8'd2,   8'd1,   32'h0E0C06FE};
        vt[1] = '{8'd127, 8'd0,   8'd1,   8'd0,   8'd1,   8'd0,   32'h80007E00};
        vt[2] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   32'h00000000};
        vt[3] = '{8'd1,   8'd2,   8'd3,   8'd4,   8'd5,   8'd6,   32'hF8280ADC};
        vt[4] = '{8'hFF,  8'h80,  8'hFE,  8'd3,   8'd4,   8'hFF,  32'hFA8E0472};
        vt[5] = '{8'h40,  8'h40,  8'h10,  8'h10,  8'h10,  8'h10,  32'h40404040};

        bus.start     = 1'b0;
        bus.num_bfly  = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        {op_ar, op_ai, op_br, op_bi, op_wr, op_wi} = '0;
        n_rst = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_outputs", outs_packed(), 32'd0);
        chk("reset_state", {28'd0, bus.state_dbg}, 32'd0);
        n_rst = 1'b1;

        do_run(1, 0, -1, -1, 1'b0);   // single butterfly plus trace
        do_run(6, 0, -1, -1, 1'b0);   // whole table back to back
        do_run(3, 3, 1, 0, 1'b0);     // input and output back-pressure
        do_run(0, 0, -1, -1, 1'b0);   // empty run
        do_run(2, 1, -1, -1, 1'b1);   // stray start while busy

        // Reset during S5 of the second butterfly.
        dn0 = done_cnt;
        @(negedge clock);
        bus.start = 1'b1; bus.num_bfly = 8'd2;
        @(negedge clock);
        bus.start = 1'b0;
        op_ar = vt[0].ar; op_ai = vt[0].ai; op_br = vt[0].br;
        op_bi = vt[0].bi; op_wr = vt[0].wr; op_wi = vt[0].wi;
        bus.in_valid = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        wt = 0;
        while (!bus.out_valid && wt < 40) begin
            @(negedge clock);
            wt++;
        end
        chk("rst_run_first_out", {31'd0, bus.out_valid}, 32'd1);
        @(negedge clock);
        bus.in_valid = 1'b1;
        chk("rst_run_idx1", {24'd0, bus.bfly_idx}, 32'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clock);
        chk("rst_run_in_s5", {31'd0, bus.s55}, 32'd1);
        n_rst = 1'b0;
        @(negedge clock);
        n_rst = 1'b1;
        chk("rst_mid_outputs", outs_packed(), 32'd0);
        chk("rst_mid_state", {28'd0, bus.state_dbg}, 32'd0);
        repeat (15) @(negedge clock);
        chk("rst_mid_no_done", done_cnt - dn0, 32'd0);
        chk("rst_mid_stays_idle", {31'd0, bus.busy}, 32'd0);

        do_run(1, 0, -1, -1, 1'b0);   // clean run after the abort

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
